// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with a per-register busy (pending producer) scoreboard.
// Optional write-to-read forwarding and a hardwired-zero register 0.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_count_q, busy_count_d;
  logic              wr0_ok, wr1_ok, issue_ok;
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd_val [2];
  logic              rd_bsy [2];

  assign wr0_ok   = wr0_en   && !(ZERO_REG != 0 && wr0_addr   == '0);
  assign wr1_ok   = wr1_en   && !(ZERO_REG != 0 && wr1_addr   == '0);
  assign issue_ok = issue_en && !(ZERO_REG != 0 && issue_addr == '0);

  // Issue is applied after write-back clears so a same-cycle issue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr0_ok)   busy_d[wr0_addr]   = 1'b0;
    if (wr1_ok)   busy_d[wr1_addr]   = 1'b0;
    if (issue_ok) busy_d[issue_addr] = 1'b1;
    if (rst)      busy_d             = '0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Later non-blocking assignment lets port 1 win on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (wr0_ok) mem_q[wr0_addr] <= wr0_data;
      if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign ra[0] = rd_addr_a;
  assign ra[1] = rd_addr_b;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_val[p] = mem_q[ra[p]];
      rd_bsy[p] = busy_q[ra[p]];
      if (BYPASS != 0) begin
        if (wr0_ok && wr0_addr == ra[p]) rd_val[p] = wr0_data;
        if (wr1_ok && wr1_addr == ra[p]) rd_val[p] = wr1_data;
        rd_bsy[p] = busy_d[ra[p]];
      end
      if (ZERO_REG != 0 && ra[p] == '0) begin
        rd_val[p] = '0;
        rd_bsy[p] = 1'b0;
      end
    end
  end

  assign rd_data_a  = rd_val[0];
  assign rd_data_b  = rd_val[1];
  assign rd_busy_a  = rd_bsy[0];
  assign rd_busy_b  = rd_bsy[1];
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: directed scenarios then random traffic against a bypass and a non-bypass instance.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr_a, rd_addr_b, wr0_addr, wr1_addr, issue_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        wr0_en, wr1_en, issue_en;

  logic [31:0] da1, db1, da0, db0;
  logic        ba1, bb1, ba0, bb0;
  logic [5:0]  cnt1, cnt0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da1), .rd_data_b(db1), .rd_busy_a(ba1), .rd_busy_b(bb1),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(cnt1)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da0), .rd_data_b(db0), .rd_busy_a(ba0), .rd_busy_b(bb0),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_count(cnt0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] da1, db1, da0, db0;
    logic        ba1, bb1, ba0, bb0;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference state: architectural register contents and pending-producer flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("byp.rd_data_a",   e.cyc, da1, e.da1);
      chk("byp.rd_data_b",   e.cyc, db1, e.db1);
      chk("byp.rd_busy_a",   e.cyc, {31'b0, ba1}, {31'b0, e.ba1});
      chk("byp.rd_busy_b",   e.cyc, {31'b0, bb1}, {31'b0, e.bb1});
      chk("byp.busy_count",  e.cyc, {26'b0, cnt1}, e.cnt);
      chk("nob.rd_data_a",   e.cyc, da0, e.da0);
      chk("nob.rd_data_b",   e.cyc, db0, e.db0);
      chk("nob.rd_busy_a",   e.cyc, {31'b0, ba0}, {31'b0, e.ba0});
      chk("nob.rd_busy_b",   e.cyc, {31'b0, bb0}, {31'b0, e.bb0});
      chk("nob.busy_count",  e.cyc, {26'b0, cnt0}, e.cnt);
    end
  end

  function automatic logic [31:0] fwd_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
    return m_regs[a];
  endfunction

  function automatic logic next_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (issue_en && issue_addr == a) return 1'b1;
    if ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int busy_total();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic drive(input logic r,
                       input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                       input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                       input logic ie,  input logic [4:0] ia,
                       input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    rst = r;
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    issue_en = ie; issue_addr = ia;
    rd_addr_a = ra; rd_addr_b = rb;
    if (!r) begin
      e.cyc = cyc;
      e.da1 = fwd_data(ra);
      e.db1 = fwd_data(rb);
      e.ba1 = next_busy(ra);
      e.bb1 = next_busy(rb);
      e.da0 = (ra == 0) ? 32'h0 : m_regs[ra];
      e.db0 = (rb == 0) ? 32'h0 : m_regs[rb];
      e.ba0 = (ra == 0) ? 1'b0 : m_busy[ra];
      e.bb0 = (rb == 0) ? 1'b0 : m_busy[rb];
      e.cnt = busy_total();
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (w0e && w0a != 0) begin m_regs[w0a] = w0d; m_busy[w0a] = 1'b0; end
      if (w1e && w1a != 0) begin m_regs[w1a] = w1d; m_busy[w1a] = 1'b0; end
      if (ie && ia != 0) m_busy[ia] = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, ra, rb);
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    rst = 1'b1;
    wr0_en = 0; wr1_en = 0; issue_en = 0;
    wr0_addr = 0; wr1_addr = 0; issue_addr = 0;
    wr0_data = 0; wr1_data = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    @(posedge clk); #1;
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) idle_read(5'(i), 5'(31 - i));

    drive(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd3, 5'd3);
    idle_read(5'd3, 5'd3);

    drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3);
    idle_read(5'd7, 5'd7);

    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd6);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
    drive(1'b0, 1'b1, 5'd5, 32'h0BADF00D, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd6);
    idle_read(5'd5, 5'd6);

    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    idle_read(5'd0, 5'd5);

    drive(1'b1, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    idle_read(5'd9, 5'd5);

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ra;
      ra = rnd_addr();
      drive(($urandom_range(0, 127) == 0),
            $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
            $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
            $urandom_range(0, 2) != 0, rnd_addr(),
            ra, ($urandom_range(0, 3) == 0) ? ra : rnd_addr());
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports rd_addr_a, rd_addr_b  input  ADDR_W  read port A/B addresses.
REQ-008 SHALL have ports rd_data_a, rd_data_b  output  DATA_W  read port A/B data, combinational.
REQ-009 SHALL have ports rd_busy_a, rd_busy_b  output  1  pending-write flag of addressed register.
REQ-010 SHALL have ports wr0_en, wr1_en  input  1  write-back port 0/1 enables.
REQ-011 SHALL have ports wr0_addr, wr1_addr  input  ADDR_W  write-back addresses.
REQ-012 SHALL have ports wr0_data, wr1_data  input  DATA_W  write-back data.
REQ-013 SHALL have port issue_en  input  1  mark issue_addr as having a pending producer.
REQ-014 SHALL have port issue_addr  input  ADDR_W  destination register being issued.
REQ-015 SHALL have port busy_count  output  ADDR_W+1  registered count of busy registers.

Function
REQ-016 SHALL hold NREGS x DATA_W storage and an NREGS-bit busy vector.
REQ-017 SHALL write wrN_data into register wrN_addr at the clock edge when wrN_en=1.
REQ-018 SHALL, when both write ports target the same address in one cycle, store wr1_data (port 1 wins).
REQ-019 SHALL clear busy[wrN_addr] at the edge for each enabled write port.
REQ-020 SHALL set busy[issue_addr] at the edge when issue_en=1.
REQ-021 SHALL, when issue and write-back target the same address in one cycle, store the write data and leave busy set (issue wins).
REQ-022 SHALL, with ZERO_REG=1, ignore writes and issues to address 0; rd_data=0 and rd_busy=0 for address 0.
REQ-023 SHALL, with BYPASS=1, return on rd_data_x the same-cycle write data when an enabled write port matches rd_addr_x (port 1 over port 0), else stored value.
REQ-024 SHALL, with BYPASS=1, drive rd_busy_x from the next-state busy bit of rd_addr_x; with BYPASS=0 from the stored bit.
REQ-025 SHALL, with BYPASS=0, return stored value only; written data visible from the cycle after the write edge.
REQ-026 SHALL update busy_count each edge to the population count of the next-state busy vector; maximum NREGS (or NREGS-1 when ZERO_REG=1), no wrap.
REQ-027 SHALL allow both read ports to address the same register, returning identical data and busy.

Reset
REQ-028 SHALL, on rst=1 at an edge, clear all registers to 0, busy vector to 0, busy_count to 0.
REQ-029 SHALL give rst priority over any write or issue in the same cycle; those are discarded.
REQ-030 SHALL present rd_data=0, rd_busy=0 for every address in the cycle after reset.

Verification
REQ-031 SHALL cover: reset, then read all addresses -> rd_data=0, rd_busy=0, busy_count=0.
REQ-032 SHALL cover: wr0 addr 3 data 0xDEADBEEF and wr1 addr 3 data 0x12345678 same cycle -> next-cycle read of r3 = 0x12345678.
REQ-033 SHALL cover: BYPASS=1, wr0 addr 7 data 0xA5A5A5A5 while rd_addr_a=7 -> rd_data_a=0xA5A5A5A5 same cycle; BYPASS=0 -> old value.
REQ-034 SHALL cover: issue r5, r6 -> busy_count=2; write-back r5 plus issue r5 same cycle -> rd_busy(r5)=1, busy_count=2.
REQ-035 SHALL cover: ZERO_REG=1, write 0xFFFFFFFF and issue to r0 -> rd_data(r0)=0, rd_busy(r0)=0, busy_count unchanged.
REQ-036 SHALL cover: rst asserted with wr0 addr 9 data 0x55 and issue r9 -> next cycle r9=0, busy_count=0.
